// File: rtl/coverage_scanner_pkg.sv
// Shared definitions for the coverage scanner: vector widths, set-operation codes,
// grid geometry and the FSM state encoding.
package coverage_scanner_pkg;

    localparam int COVERED_SZ = 3;
    localparam int MODE_SZ    = 2;
    localparam int GRID_SZ    = 8;
    localparam int NUM_PTS    = GRID_SZ * GRID_SZ;

    localparam logic [MODE_SZ-1:0] MODE1 = 2'd0;
    localparam logic [MODE_SZ-1:0] MODE2 = 2'd1;
    localparam logic [MODE_SZ-1:0] MODE3 = 2'd2;
    localparam logic [MODE_SZ-1:0] MODE4 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/coverage_scanner_in_circle.sv
// Single-circle membership test: (x-xc)^2 + (y-yc)^2 <= r^2, evaluated
// at full precision so off-grid centres never alias onto the grid.
module in_circle (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [3:0] xc,
    input  logic [3:0] yc,
    input  logic [3:0] r,
    output logic       in
);

    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic        [3:0] dx_mag;
    logic        [3:0] dy_mag;
    logic        [7:0] dx_sq;
    logic        [7:0] dy_sq;
    logic        [7:0] r_sq;
    logic        [8:0] dist_sq;

    assign dx = $signed({1'b0, x}) - $signed({1'b0, xc});
    assign dy = $signed({1'b0, y}) - $signed({1'b0, yc});

    // Differences span -15..15, so the magnitude always fits in 4 bits.
    assign dx_mag = dx[4] ? 4'(-dx) : dx[3:0];
    assign dy_mag = dy[4] ? 4'(-dy) : dy[3:0];

    assign dx_sq   = {4'd0, dx_mag} * {4'd0, dx_mag};
    assign dy_sq   = {4'd0, dy_mag} * {4'd0, dy_mag};
    assign r_sq    = {4'd0, r} * {4'd0, r};
    assign dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};

    assign in = (dist_sq <= {1'b0, r_sq});

endmodule

// File: rtl/coverage_scanner.sv
// Scans an 8x8 grid against three latched circles, one point per cycle, and counts
// the points for which the external set-operation unit reports a hit.
module coverage_scanner
    import coverage_scanner_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [23:0]           central_i,
    input  logic [11:0]           radius_i,
    input  logic [MODE_SZ-1:0]    mode_i,
    output logic                  busy_o,
    output logic                  scan_vld_o,
    output logic [COVERED_SZ-1:0] covered_o,
    output logic [MODE_SZ-1:0]    mode_buf_o,
    input  logic                  hit_i,
    output logic                  valid_o,
    output logic [7:0]            candidate_o
);

    state_e               state_q,     state_d;
    logic [5:0]           idx_q,       idx_d;
    logic [6:0]           count_q,     count_d;
    logic [23:0]          central_q,   central_d;
    logic [11:0]          radius_q,    radius_d;
    logic [MODE_SZ-1:0]   mode_q,      mode_d;
    logic [7:0]           candidate_q, candidate_d;

    logic [3:0]            pt_x;
    logic [3:0]            pt_y;
    logic [COVERED_SZ-1:0] in_bits;

    assign pt_x = {1'b0, idx_q[2:0]} + 4'd1;
    assign pt_y = {1'b0, idx_q[5:3]} + 4'd1;

    // Instance k tests the circle whose membership lands on covered bit k (bit 2 = A).
    for (genvar k = 0; k < COVERED_SZ; k++) begin : g_circle
        in_circle u_in_circle (
            .x  (pt_x),
            .y  (pt_y),
            .xc (central_q[k*8+4 +: 4]),
            .yc (central_q[k*8   +: 4]),
            .r  (radius_q[k*4 +: 4]),
            .in (in_bits[k])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            central_q   <= '0;
            radius_q    <= '0;
            mode_q      <= '0;
            candidate_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            central_q   <= central_d;
            radius_q    <= radius_d;
            mode_q      <= mode_d;
            candidate_q <= candidate_d;
        end
    end

    // NOTE: every next-state signal takes its hold value first so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        central_d   = central_q;
        radius_d    = radius_q;
        mode_d      = mode_q;
        candidate_d = candidate_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d   = ST_SCAN;
                    idx_d     = '0;
                    count_d   = '0;
                    central_d = central_i;
                    radius_d  = radius_i;
                    mode_d    = mode_i;
                end
            end
            ST_SCAN: begin
                idx_d = idx_q + 6'd1;
                if (hit_i) begin
                    count_d = count_q + 7'd1;
                end
                if (idx_q == 6'(NUM_PTS - 1)) begin
                    state_d     = ST_DONE;
                    candidate_d = {1'b0, count_q + {6'd0, hit_i}};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign scan_vld_o  = (state_q == ST_SCAN);
    assign valid_o     = (state_q == ST_DONE);
    assign covered_o   = scan_vld_o ? in_bits : '0;
    assign mode_buf_o  = mode_q;
    assign candidate_o = candidate_q;

endmodule

// File: tb/tb_coverage_scanner.sv
// Self-checking bench for coverage_scanner: acts as the external set-operation unit
// and compares every job against a geometric reference model.
module tb_coverage_scanner;
    import coverage_scanner_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic [23:0]           central_i;
    logic [11:0]           radius_i;
    logic [MODE_SZ-1:0]    mode_i;
    logic                  busy_o;
    logic                  scan_vld_o;
    logic [COVERED_SZ-1:0] covered_o;
    logic [MODE_SZ-1:0]    mode_buf_o;
    logic                  hit_i;
    logic                  valid_o;
    logic [7:0]            candidate_o;

    int checks = 0;
    int errors = 0;

    logic [2:0]         cov_obs [64];
    int                 obs_scan;
    int                 obs_lat;
    logic [7:0]         obs_cand;
    logic [MODE_SZ-1:0] obs_mode;

    coverage_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .central_i   (central_i),
        .radius_i    (radius_i),
        .mode_i      (mode_i),
        .busy_o      (busy_o),
        .scan_vld_o  (scan_vld_o),
        .covered_o   (covered_o),
        .mode_buf_o  (mode_buf_o),
        .hit_i       (hit_i),
        .valid_o     (valid_o),
        .candidate_o (candidate_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set-operation unit: MODE1 union, MODE2 A&B, MODE3 A&B&C, MODE4 odd parity.
    function automatic logic lu(input logic [2:0] cov, input logic [MODE_SZ-1:0] m);
        case (m)
            MODE1:   return |cov;
            MODE2:   return cov[2] & cov[1];
            MODE3:   return &cov;
            default: return ^cov;
        endcase
    endfunction

    assign hit_i = lu(covered_o, mode_buf_o);

    function automatic logic [2:0] model_cov(input logic [23:0] c, input logic [11:0] r, input int idx);
        logic [2:0] res;
        int x, y, xc, yc, rr;
        x = idx % 8 + 1;
        y = idx / 8 + 1;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            xc = int'((c >> (20 - 8 * k)) & 24'hF);
            yc = int'((c >> (16 - 8 * k)) & 24'hF);
            rr = int'((r >> (8 - 4 * k)) & 12'hF);
            res[2-k] = ((x - xc) * (x - xc) + (y - yc) * (y - yc)) <= rr * rr;
        end
        return res;
    endfunction

    function automatic int model_count(input logic [23:0] c, input logic [11:0] r, input logic [MODE_SZ-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(lu(model_cov(c, r, i), m));
        return n;
    endfunction

    // Starts a job from IDLE and records what the DUT shows until its valid pulse.
    task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [MODE_SZ-1:0] m);
        en = 1'b1; central_i = c; radius_i = r; mode_i = m;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; central_i = $urandom; radius_i = 12'($urandom); mode_i = MODE_SZ'($urandom);
        obs_scan = 0; obs_lat = 0; obs_cand = '0; obs_mode = mode_buf_o;
        for (int i = 0; i < 64; i++) cov_obs[i] = 3'bxxx;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (scan_vld_o) begin
                if (obs_scan < 64) cov_obs[obs_scan] = covered_o;
                obs_scan++;
            end
            if (valid_o) begin
                obs_lat  = cyc;
                obs_cand = candidate_o;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; central_i = '0; radius_i = '0; mode_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (scan_vld_o !== 1'b0)  begin errors++; $display("FAIL reset_scan_vld got=%b exp=0", scan_vld_o); end
        checks++; if (valid_o !== 1'b0)     begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (candidate_o !== 8'd0) begin errors++; $display("FAIL reset_candidate got=%0d exp=0", candidate_o); end
        checks++; if (covered_o !== 3'b000) begin errors++; $display("FAIL reset_covered got=%b exp=000", covered_o); end
        checks++; if (mode_buf_o !== '0)    begin errors++; $display("FAIL reset_mode_buf got=%0d exp=0", mode_buf_o); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL idle_after_reset busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_single_point();
        run_job(24'h440000, 12'h000, MODE1);
        checks++; if (obs_lat !== 65)        begin errors++; $display("FAIL single_latency got=%0d exp=65", obs_lat); end
        checks++; if (obs_scan !== 64)       begin errors++; $display("FAIL single_scan_len got=%0d exp=64", obs_scan); end
        checks++; if (obs_cand !== 8'd1)     begin errors++; $display("FAIL single_candidate got=%0d exp=1", obs_cand); end
        checks++; if (obs_mode !== MODE1)    begin errors++; $display("FAIL single_mode_buf got=%0d exp=%0d", obs_mode, MODE1); end
        for (int i = 0; i < 64; i++) begin
            logic [2:0] exp_cov;
            exp_cov = (i == 27) ? 3'b100 : 3'b000;
            checks++;
            if (cov_obs[i] !== exp_cov) begin
                errors++; $display("FAIL single_covered idx=%0d got=%b exp=%b", i, cov_obs[i], exp_cov);
            end
        end
        checks++; if (candidate_o !== 8'd1)  begin errors++; $display("FAIL single_hold got=%0d exp=1", candidate_o); end
        checks++; if (valid_o !== 1'b0)      begin errors++; $display("FAIL single_valid_width got=%b exp=0", valid_o); end
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL single_idle busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_saturation();
        run_job(24'h440000, 12'h800, MODE1);
        checks++; if (obs_cand !== 8'd64) begin errors++; $display("FAIL saturation_candidate got=%0d exp=64", obs_cand); end
        checks++; if (obs_lat !== 65)     begin errors++; $display("FAIL saturation_latency got=%0d exp=65", obs_lat); end
    endtask

    task automatic test_intersection();
        run_job(24'h335300, 12'h220, MODE2);
        checks++; if (obs_cand !== 8'd5)  begin errors++; $display("FAIL intersection_candidate got=%0d exp=5", obs_cand); end
        checks++; if (obs_mode !== MODE2) begin errors++; $display("FAIL intersection_mode_buf got=%0d exp=%0d", obs_mode, MODE2); end
    endtask

    task automatic test_off_grid();
        int hits;
        run_job(24'hFF0000, 12'h100, MODE1);
        checks++; if (obs_cand !== 8'd0) begin errors++; $display("FAIL offgrid_candidate got=%0d exp=0", obs_cand); end
        hits = 0;
        for (int i = 0; i < 64; i++) if (cov_obs[i][2] !== 1'b0) hits++;
        checks++; if (hits !== 0) begin errors++; $display("FAIL offgrid_covered_a got=%0d points exp=0", hits); end
    endtask

    task automatic test_abort();
        int pulses;
        en = 1'b1; central_i = 24'h440000; radius_i = 12'h800; mode_i = MODE1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (scan_vld_o !== 1'b1) begin errors++; $display("FAIL abort_in_scan got=%b exp=1", scan_vld_o); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        checks++; if (candidate_o !== 8'd0) begin errors++; $display("FAIL abort_candidate got=%0d exp=0", candidate_o); end
        checks++; if (covered_o !== 3'b000) begin errors++; $display("FAIL abort_covered got=%b exp=000", covered_o); end
        pulses = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (valid_o) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_valid got=%0d pulses exp=0", pulses); end
        run_job(24'h440000, 12'h000, MODE1);
        checks++; if (obs_cand !== 8'd1) begin errors++; $display("FAIL abort_next_job got=%0d exp=1", obs_cand); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            logic [23:0]        c;
            logic [11:0]        r;
            logic [MODE_SZ-1:0] m;
            int                 exp_n;
            c = 24'($urandom);
            r = 12'($urandom);
            m = MODE_SZ'($urandom);
            exp_n = model_count(c, r, m);
            run_job(c, r, m);
            checks++; if (obs_cand !== 8'(exp_n)) begin errors++; $display("FAIL random_candidate job=%0d got=%0d exp=%0d", j, obs_cand, exp_n); end
            checks++; if (obs_lat !== 65)         begin errors++; $display("FAIL random_latency job=%0d got=%0d exp=65", j, obs_lat); end
            checks++; if (obs_mode !== m)         begin errors++; $display("FAIL random_mode_buf job=%0d got=%0d exp=%0d", j, obs_mode, m); end
            for (int i = 0; i < 64; i++) begin
                logic [2:0] exp_cov;
                exp_cov = model_cov(c, r, i);
                checks++;
                if (cov_obs[i] !== exp_cov) begin
                    errors++; $display("FAIL random_covered job=%0d idx=%0d got=%b exp=%b", j, i, cov_obs[i], exp_cov);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0]        jc [3];
        logic [11:0]        jr [3];
        logic [MODE_SZ-1:0] jm [3];
        int                 exp_q [$];
        int                 started, valid_cnt, last_valid, exp_n;
        for (int k = 0; k < 3; k++) begin
            jc[k] = 24'($urandom); jr[k] = 12'($urandom); jm[k] = MODE_SZ'($urandom);
        end
        started = 0; valid_cnt = 0; last_valid = -1;
        en = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (valid_o) begin
                exp_n = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++;
                if (candidate_o !== 8'(exp_n)) begin
                    errors++; $display("FAIL b2b_candidate job=%0d got=%0d exp=%0d", valid_cnt, candidate_o, exp_n);
                end
                if (last_valid >= 0) begin
                    checks++;
                    if (cyc - last_valid !== 66) begin
                        errors++; $display("FAIL b2b_period got=%0d exp=66", cyc - last_valid);
                    end
                end
                last_valid = cyc;
                valid_cnt++;
            end
            if (valid_cnt == 3) break;
            if (!busy_o && started < 3) begin
                central_i = jc[started]; radius_i = jr[started]; mode_i = jm[started];
                exp_q.push_back(model_count(jc[started], jr[started], jm[started]));
                started++;
            end else if (!busy_o) begin
                en = 1'b0;
            end else begin
                central_i = 24'($urandom); radius_i = 12'($urandom); mode_i = MODE_SZ'($urandom);
            end
            @(negedge clk);
        end
        en = 1'b0;
        checks++; if (valid_cnt !== 3) begin errors++; $display("FAIL b2b_job_count got=%0d exp=3", valid_cnt); end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_point();
        test_saturation();
        test_abort();
        test_intersection();
        test_off_grid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
